conv_mac_accumulator: RTL
=========================

Name: conv_mac_accumulator

Overview:
Upstream stage of the quantization block. Streams one convolution window of KERNEL_SIZE (activation, weight) pairs and subtracts the zero points. Multiplies and accumulates onto a signed bias in a pipelined MAC. Presents the finished accumulator, sign-extended to 65 bits, on the quantizer's `a`/`en` interface, then holds off for the quantizer's fixed latency.

Parameters:
KERNEL_SIZE, 9, taps per window (3x3); must be ≥1
DATA_W, 8, activation/weight width
ACC_W, 32, internal signed accumulator width
OUT_W, 65, output width, matches quantizer input
INPUT_ZP, 0, activation zero point (unsigned, 0..255)
WEIGHT_ZP, 0, weight zero point (signed)
QUANT_LAT, 12, cycles to hold off after out_en so the quantizer's sequence completes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a window; sampled only in IDLE
bias  in  32  signed bias; sampled on accepted start
in_valid  in  1  tap pair present
in_ready  out  1  block accepts tap this cycle
pixel  in  DATA_W  unsigned activation
weight  in  DATA_W  signed weight
acc_out  out  OUT_W  sign-extended accumulator to quantizer `a`
out_en  out  1  one-cycle strobe to quantizer `en`
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on return to IDLE after hold-off

Behaviour:
- Reset values: in_ready=0, out_en=0, done=0, busy=0, acc_out=0. Internal state: acc=0, tap count=0, p_valid=0, state=IDLE.
- States: IDLE -> ACCUM -> DRAIN -> EMIT -> HOLD -> IDLE.
- IDLE:
  - start=1: acc<=sign-ext(bias), count<=0, go to ACCUM.
  - in_ready=0, so a tap presented in the same cycle as start is not accepted.
- ACCUM:
  - in_ready=1.
  - Handshake in_valid&in_ready:
    - p <= (pixel-INPUT_ZP)*(weight-WEIGHT_ZP), using 9-bit signed operands and an 18-bit signed product.
    - p_valid<=1, count++.
  - No handshake: p_valid<=0.
  - Gaps in in_valid are allowed, unbounded.
  - When the accepted tap has count==KERNEL_SIZE-1, go to DRAIN.
- Accumulate: on every cycle with p_valid=1, acc <= acc + sign-ext(p). Two's-complement wrap on overflow; see the optional feature for saturation.
- DRAIN:
  - in_ready=0.
  - The last product is added; go to EMIT.
- EMIT:
  - out_en=1 for exactly one cycle.
  - acc_out <= sign-ext(acc) to OUT_W, registered on entry to EMIT.
  - Go to HOLD, hold counter=0.
- HOLD:
  - out_en=0.
  - acc_out stays stable, because the quantizer multiplies it combinationally.
  - After QUANT_LAT cycles go to IDLE and pulse done.
- acc_out holds its last value until the next EMIT.
- Latency: out_en is high two cycles after the clock edge that accepts the final tap.
- Boundary conditions:
  - start outside IDLE is ignored.
  - in_valid outside ACCUM is ignored; no tap is consumed.
  - KERNEL_SIZE=1 gives ACCUM for exactly one handshake.
  - rst in any state: immediately to IDLE. The window is discarded with no out_en and no done. acc_out is cleared to 0.
  - rst and start in the same cycle: rst wins.

Optional Feature:
ACC_SAT_EN
- Defined:
  - Accumulate saturates at [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Adds output port ovf (1 bit), sticky within a window. Set on any clamp, cleared on accepted start, reset to 0.
  - ovf is valid with out_en.
- Undefined:
  - Two's-complement wrap.
  - No ovf port.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W, ACC_W, OUT_W, QUANT_LAT constants
  - mac_state_t enum (IDLE, ACCUM, DRAIN, EMIT, HOLD)
  - sign-extend helper function
- Sub-module mac_product: zero-point subtraction, 9x9 signed multiply, and the registered product with p_valid.
- Top level owns the FSM, counters and accumulator.

Test Plan:
- Defaults, bias=10, 9 taps pixel=1 weight=2 -> out_en once, acc_out=28; done pulses 12 cycles after out_en.
- INPUT_ZP=128, pixel=0, weight=-1 ×9, bias=0 -> acc_out=1152.
- pixel=255, weight=-128 ×9, bias=-5 -> acc_out=-293765; bits 64..31 all 1.
- Backpressure: in_valid toggles 1,0,0,1 pattern with pixel=3 weight=3 ×9, bias=0 -> acc_out=81; in_ready=0 in DRAIN/EMIT/HOLD; a start pulsed during HOLD is ignored.
- rst asserted after 4 taps -> state IDLE next cycle, acc_out=0, no out_en/done. A fresh window afterwards gives the correct result.
- bias=2147483647, pixel=1 weight=1 ×9:
  - Without ACC_SAT_EN -> acc_out=-2147483640.
  - With ACC_SAT_EN -> acc_out=2147483647, ovf=1; ovf clears on next start.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution MAC front end of the quantization block.
// Holds the datapath widths, the quantizer hold-off latency, the MAC FSM state type
// and a helper that sign-extends the accumulator onto the quantizer's 65-bit input.
package cnn_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned OUT_W     = 65;
  localparam int unsigned QUANT_LAT = 12;
  // Zero-point-corrected operands are 9-bit signed, so the product fits in 18 bits.
  localparam int unsigned OPND_W    = DATA_W + 1;
  localparam int unsigned PROD_W    = 2 * OPND_W;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StEmit,
    StHold
  } mac_state_t;

  function automatic logic [OUT_W-1:0] sext_acc(input logic [ACC_W-1:0] a);
    return {{(OUT_W - ACC_W){a[ACC_W-1]}}, a};
  endfunction

endpackage

// File: rtl/mac_product.sv
// Zero-point correction and product register of the convolution MAC.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            tap handshake (in_valid & in_ready) this cycle
//   pixel         unsigned activation
//   weight        signed weight
//   p             registered signed product of the last accepted tap
//   p_valid       high for one cycle after each accepted tap
module mac_product
  import cnn_pkg::*;
#(
  parameter int unsigned INPUT_ZP  = 0,
  parameter int          WEIGHT_ZP = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        pixel,
  input  logic [DATA_W-1:0]        weight,
  output logic signed [PROD_W-1:0] p,
  output logic                     p_valid
);

  localparam logic [OPND_W-1:0] InZp = OPND_W'(INPUT_ZP);
  localparam logic [OPND_W-1:0] WtZp = OPND_W'(WEIGHT_ZP);

  logic signed [OPND_W-1:0] a_s, b_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] p_d, p_q;
  logic                     p_valid_d, p_valid_q;

  always_comb begin
    a_s       = $signed({1'b0, pixel} - InZp);
    b_s       = $signed({weight[DATA_W-1], weight} - WtZp);
    prod      = a_s * b_s;
    p_d       = en ? prod : p_q;
    p_valid_d = en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p       = p_q;
  assign p_valid = p_valid_q;

endmodule

// File: rtl/conv_mac_accumulator.sv
// Convolution window MAC feeding the quantizer's a/en interface.
// Accepts KERNEL_SIZE (pixel, weight) taps, accumulates the zero-point-corrected products
// onto a signed bias, emits the sign-extended result with a one-cycle out_en, then holds
// acc_out stable until the quantizer's fixed latency has elapsed and pulses done.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, bias            open a window (IDLE only), bias sampled with start
//   in_valid, in_ready     tap handshake; pixel (unsigned), weight (signed)
//   acc_out, out_en        result and strobe to the quantizer
//   busy, done             not-idle flag, end-of-hold-off pulse
//   ovf                    sticky clamp flag (only with ACC_SAT_EN)
// Build option: define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module conv_mac_accumulator
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 9,
  parameter int unsigned INPUT_ZP    = 0,
  parameter int          WEIGHT_ZP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [OUT_W-1:0]  acc_out,
  output logic              out_en,
  output logic              busy,
`ifdef ACC_SAT_EN
  output logic              ovf,
`endif
  output logic              done
);

  localparam int unsigned CntW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned HoldW = $clog2(QUANT_LAT) + 1;
  localparam logic [CntW-1:0]  CntLast  = CntW'(KERNEL_SIZE - 1);
  // The EMIT cycle counts as the first hold-off cycle, so HOLD lasts QUANT_LAT-1 cycles.
  localparam logic [HoldW-1:0] HoldLast = HoldW'(QUANT_LAT - 2);

  mac_state_t state_d, state_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic [HoldW-1:0] hold_d, hold_q;
  logic [ACC_W-1:0] acc_d, acc_q, acc_sum;
  logic [OUT_W-1:0] acc_out_d, acc_out_q;
  logic             out_en_d, out_en_q;
  logic             done_d, done_q;
  logic             tap_hs;
  logic signed [PROD_W-1:0] p;
  logic             p_valid;

  assign in_ready = (state_q == StAccum);
  assign busy     = (state_q != StIdle);
  assign tap_hs   = in_valid & in_ready;

  mac_product #(
    .INPUT_ZP  (INPUT_ZP),
    .WEIGHT_ZP (WEIGHT_ZP)
  ) u_mac_product (
    .clk     (clk),
    .rst     (rst),
    .en      (tap_hs),
    .pixel   (pixel),
    .weight  (weight),
    .p       (p),
    .p_valid (p_valid)
  );

`ifdef ACC_SAT_EN
  logic signed [ACC_W:0] sum_wide;
  logic                  clamp;
  logic                  ovf_d, ovf_q;

  always_comb begin
    sum_wide = $signed({acc_q[ACC_W-1], acc_q}) + (ACC_W + 1)'(p);
    // Overflow shows up as disagreement between the guard bit and the result sign.
    clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (!clamp)               acc_sum = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) acc_sum = {1'b1, {(ACC_W - 1){1'b0}}};
    else                      acc_sum = {1'b0, {(ACC_W - 1){1'b1}}};
  end

  assign ovf = ovf_q;
`else
  always_comb acc_sum = acc_q + ACC_W'(p);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    acc_d     = p_valid ? acc_sum : acc_q;
    acc_out_d = acc_out_q;
    out_en_d  = 1'b0;
    done_d    = 1'b0;
`ifdef ACC_SAT_EN
    ovf_d     = ovf_q | (p_valid & clamp);
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          acc_d   = bias;
          cnt_d   = '0;
`ifdef ACC_SAT_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StAccum: begin
        if (tap_hs) begin
          if (cnt_q == CntLast) state_d = StDrain;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        // acc_d already includes the final product added this cycle.
        state_d   = StEmit;
        out_en_d  = 1'b1;
        acc_out_d = sext_acc(acc_d);
      end
      StEmit: begin
        state_d = StHold;
        hold_d  = '0;
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hold_q    <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      out_en_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef ACC_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      out_en_q  <= out_en_d;
      done_q    <= done_d;
`ifdef ACC_SAT_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign acc_out = acc_out_q;
  assign out_en  = out_en_q;
  assign done    = done_q;

endmodule
